alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: start  input  1  operation request, sampled on rising clk edges.
REQ-004 SHALL provide: alu_ctrl  input  4  operation code (Function table).
REQ-005 SHALL provide: op_a  input  32  first operand.
REQ-006 SHALL provide: op_b  input  32  second operand or shift amount (bits [4:0]).
REQ-007 SHALL provide: imm  input  16  signed immediate, used by ADDI only.
REQ-008 SHALL provide: ready  output  1  high when start will be accepted.
REQ-009 SHALL provide: done  output  1  one-cycle pulse; result outputs valid.
REQ-010 SHALL provide: result  output  32  result, or low word of product.
REQ-011 SHALL provide: result_hi  output  32  high word of product; 0 for non-MULT.
REQ-012 SHALL provide: zero  output  1  result (all 64 bits for MULT) equals 0.
REQ-013 SHALL provide: ovf  output  1  signed overflow, ADD/ADDI/SUB only.
REQ-014 SHALL provide: illegal  output  1  unsupported alu_ctrl code.

Function
REQ-015 Codes SHALL be: 0000 AND, 0010 OR, 0011 XOR, 0100 ADD, 0101 ADDI (op_a + sign-extended imm), 1100 SUB (op_a - op_b), 0001 SLL, 0110 SRL (logical), 0111 MULT (unsigned 32x32 -> 64).
REQ-016 Start SHALL be accepted on an edge where start=1 and ready=1; alu_ctrl, op_a, op_b, imm SHALL be captured then and later changes ignored.
REQ-017 States SHALL be IDLE and MUL; ready=1 exactly when state is IDLE.
REQ-018 Non-MULT ops SHALL stay in IDLE; done=1 with registered result in the cycle after acceptance; back-to-back acceptance every cycle allowed.
REQ-019 MULT SHALL move IDLE->MUL, run 32 shift-add iterations, and assert done in the cycle after the 32nd edge following acceptance, returning to IDLE in that same cycle.
REQ-020 start while ready=0 SHALL be ignored with no effect on state or outputs.
REQ-021 start in a cycle where done=1 and ready=1 SHALL be accepted normally.
REQ-022 Shifts SHALL use op_b[4:0] only; upper bits ignored.
REQ-023 Add/sub SHALL wrap modulo 2^32; ovf set when operand signs match (SUB: differ) and result sign differs from op_a.
REQ-024 Unlisted codes SHALL set illegal=1, result=0, result_hi=0, zero=1, ovf=0, with done timing as a non-MULT op.
REQ-025 result, result_hi, zero, ovf, illegal SHALL hold until the next done; done SHALL be low otherwise.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, ready=1, done=0, result=0, result_hi=0, zero=0, ovf=0, illegal=0, iteration counter=0.
REQ-027 Reset during MUL SHALL abort the multiply with no done pulse afterward.

Structure
REQ-028 The opcode constants and state enumeration SHALL live in shared package alu_pkg, also imported by the ALU control decoder.
REQ-029 The iterative multiplier SHALL be sub-module alu_mult_seq (start/busy/done, 6-bit counter, 64-bit accumulator).

Verification
REQ-030 ADD op_a=0x7FFFFFFF, op_b=1 -> next cycle done=1, result=0x80000000, ovf=1, zero=0.
REQ-031 SUB 5-5 -> result=0, zero=1, ovf=0; ADDI op_a=10, imm=0xFFFF -> result=9.
REQ-032 SLL op_a=1, op_b=0x23 -> result=8; SRL op_a=0x80000000, op_b=31 -> result=1.
REQ-033 MULT 0xFFFFFFFF x 0xFFFFFFFF -> ready low 32 cycles, done exactly 32 cycles after acceptance, result_hi=0xFFFFFFFE, result=0x00000001; start pulses while busy ignored.
REQ-034 rst_n low at MUL cycle 10 -> all outputs at reset values, ready=1, no later done; then alu_ctrl=1111 -> illegal=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, decoded-op and FSM state types
//
// Purpose : single home for the alu_ctrl encodings, the decoded operation
//           enumeration and the execution-unit state enumeration, so the
//           decoder and the top-level agree on every code.
// Ports   : none (package)
package alu_pkg;

  localparam int XLEN = 32;

  // alu_ctrl encodings
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_SLL  = 4'b0001;
  localparam logic [3:0] CTRL_OR   = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_ADD  = 4'b0100;
  localparam logic [3:0] CTRL_ADDI = 4'b0101;
  localparam logic [3:0] CTRL_SRL  = 4'b0110;
  localparam logic [3:0] CTRL_MULT = 4'b0111;
  localparam logic [3:0] CTRL_SUB  = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADD,
    OP_ADDI,
    OP_SUB,
    OP_SLL,
    OP_SRL,
    OP_MULT,
    OP_ILLEGAL
  } op_e;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - alu_ctrl opcode decoder
//
// Purpose : maps the raw 4-bit alu_ctrl code onto the decoded op_e and flags
//           codes that are not in the function table.
// Ports   : alu_ctrl_i [3:0] - raw operation code
//           op_o             - decoded operation
//           illegal_o        - code is not supported
//           is_mult_o        - code selects the iterative multiplier
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [3:0] alu_ctrl_i,
  output op_e        op_o,
  output logic       illegal_o,
  output logic       is_mult_o
);

  always_comb begin
    op_o = OP_ILLEGAL;
    case (alu_ctrl_i)
      CTRL_AND:  op_o = OP_AND;
      CTRL_OR:   op_o = OP_OR;
      CTRL_XOR:  op_o = OP_XOR;
      CTRL_ADD:  op_o = OP_ADD;
      CTRL_ADDI: op_o = OP_ADDI;
      CTRL_SUB:  op_o = OP_SUB;
      CTRL_SLL:  op_o = OP_SLL;
      CTRL_SRL:  op_o = OP_SRL;
      CTRL_MULT: op_o = OP_MULT;
      default:   op_o = OP_ILLEGAL;
    endcase
  end

  assign illegal_o = (op_o == OP_ILLEGAL);
  assign is_mult_o = (op_o == OP_MULT);

endmodule

// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - unsigned 32x32 shift-add multiplier, one bit per cycle
//
// Purpose : iterative multiplier. start_i loads the operands; each of the
//           following 32 clock edges retires one multiplier bit.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           start_i         - load operands (ignored while busy)
//           a_i, b_i [31:0] - multiplicand, multiplier
//           busy_o          - iteration in progress
//           done_o          - the current cycle performs the last iteration;
//                             prod_o is the finished product at the next edge
//           prod_o [63:0]   - accumulator value after the current iteration
module alu_mult_seq
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [2*XLEN-1:0] prod_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [5:0]        cnt_q;
  logic              busy_q;

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = busy_q && (cnt_q == 6'd31);
  // Exposing the next accumulator lets the parent register the product on
  // the same edge as the final iteration instead of one cycle later.
  assign prod_o = acc_d;
  assign busy_o = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i && !busy_q) begin
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - single-issue ALU execution unit with iterative multiply
//
// Purpose : executes one ALU operation per accepted start. Single-cycle ops
//           return done on the next cycle; MULT occupies the unit for 32
//           cycles via alu_mult_seq.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           start             - operation request
//           alu_ctrl [3:0]    - operation code
//           op_a, op_b [31:0] - operands (op_b[4:0] is the shift amount)
//           imm [15:0]        - signed immediate for ADDI
//           ready             - unit idle, start will be accepted
//           done              - one-cycle pulse, result outputs updated
//           result [31:0]     - result / low product word
//           result_hi [31:0]  - high product word (0 otherwise)
//           zero              - full result is zero
//           ovf               - signed overflow for ADD/ADDI/SUB
//           illegal           - unsupported alu_ctrl code
module alu_exec
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [15:0]     imm,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] result_hi,
  output logic            zero,
  output logic            ovf,
  output logic            illegal
);

  state_e            state_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [XLEN-1:0]   result_hi_q;
  logic              zero_q;
  logic              ovf_q;
  logic              illegal_q;

  op_e               op;
  logic              dec_illegal;
  logic              dec_is_mult;

  logic [XLEN-1:0]   b_eff;
  logic [XLEN-1:0]   sum;
  logic [XLEN-1:0]   diff;
  logic [XLEN-1:0]   res_d;
  logic              ovf_d;
  logic              zero_d;

  logic              accept;
  logic              mult_busy;
  logic              mult_done;
  logic [2*XLEN-1:0] mult_prod;

  assign ready  = (state_q == ST_IDLE);
  assign accept = start && ready;

  alu_ctrl_dec u_dec (
    .alu_ctrl_i (alu_ctrl),
    .op_o       (op),
    .illegal_o  (dec_illegal),
    .is_mult_o  (dec_is_mult)
  );

  alu_mult_seq u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && dec_is_mult),
    .a_i     (op_a),
    .b_i     (op_b),
    .busy_o  (mult_busy),
    .done_o  (mult_done),
    .prod_o  (mult_prod)
  );

  // ADD and ADDI share one adder; only the second operand differs.
  assign b_eff = (op == OP_ADDI) ? sext16(imm) : op_b;
  assign sum   = op_a + b_eff;
  assign diff  = op_a - op_b;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (op)
      OP_AND:  res_d = op_a & op_b;
      OP_OR:   res_d = op_a | op_b;
      OP_XOR:  res_d = op_a ^ op_b;
      OP_ADD,
      OP_ADDI: begin
        res_d = sum;
        ovf_d = (op_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
      end
      OP_SLL:  res_d = op_a << op_b[4:0];
      OP_SRL:  res_d = op_a >> op_b[4:0];
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  assign zero_d = (res_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (dec_is_mult) begin
              // Previous results stay visible until the product lands.
              state_q <= ST_MUL;
            end else begin
              done_q      <= 1'b1;
              result_q    <= res_d;
              result_hi_q <= '0;
              zero_q      <= zero_d;
              ovf_q       <= ovf_d;
              illegal_q   <= dec_illegal;
            end
          end
        end
        ST_MUL: begin
          if (mult_done) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b1;
            result_q    <= mult_prod[XLEN-1:0];
            result_hi_q <= mult_prod[2*XLEN-1:XLEN];
            zero_q      <= (mult_prod == '0);
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
          end else if (!mult_busy) begin
            // Multiplier idle while we wait on it: recover rather than hang.
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec with randomized ops
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [15:0] imm = 16'd0;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        ovf;
  logic        illegal;

  alu_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .imm       (imm),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] r;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        ill;
    int          dcyc;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  exp_t sb[$];
  int   cyc = 0;
  int   mult_acc = -1000;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Ready is low for the 32 cycles following a MULT acceptance in cycle mult_acc.
  function automatic bit busy_at(input int n);
    return (n > mult_acc) && (n <= mult_acc + 32);
  endfunction

  function automatic exp_t ref_model(input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b, input logic [15:0] im);
    exp_t        e;
    longint      s;
    logic [63:0] p;
    logic [31:0] ie;
    e.r = 32'd0; e.hi = 32'd0; e.o = 1'b0; e.ill = 1'b0; e.dcyc = 0;
    ie = {{16{im[15]}}, im};
    s = 0;
    case (c)
      4'b0000: e.r = a & b;
      4'b0010: e.r = a | b;
      4'b0011: e.r = a ^ b;
      4'b0100: begin
        e.r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.o = (s > SMAX) || (s < SMIN);
      end
      4'b0101: begin
        e.r = a + ie;
        s = longint'($signed(a)) + longint'($signed(ie));
        e.o = (s > SMAX) || (s < SMIN);
      end
      4'b1100: begin
        e.r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.o = (s > SMAX) || (s < SMIN);
      end
      4'b0001: e.r = a << (b % 32);
      4'b0110: e.r = a >> (b % 32);
      4'b0111: begin
        p = {32'd0, a} * {32'd0, b};
        e.r = p[31:0];
        e.hi = p[63:32];
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == 32'd0) && (e.hi == 32'd0);
    return e;
  endfunction

  // Called just after a rising edge; the request is sampled on the next edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] im);
    int   n;
    exp_t e;
    start = 1'b1; alu_ctrl = c; op_a = a; op_b = b; imm = im;
    n = cyc;
    if (!busy_at(n)) begin
      e = ref_model(c, a, b, im);
      e.dcyc = n + 1 + ((c == 4'b0111) ? 32 : 0);
      sb.push_back(e);
      if (c == 4'b0111) mult_acc = n;
    end
    @(posedge clk); #1;
    start = 1'b0;
    alu_ctrl = 4'($urandom_range(15));
    op_a = $urandom;
    op_b = $urandom;
    imm = 16'($urandom);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] opnd();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(40));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_result_hi"}, 64'(result_hi), 64'd0);
    chk({tag, "_zero"}, 64'(zero), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal), 64'd0);
  endtask

  // Monitor: checks ready every cycle and scores every done pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && mon_en) begin
      chk("ready", 64'(ready), 64'(!busy_at(cyc)));
      while (sb.size() > 0 && sb[0].dcyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_done: got none, want done at cycle %0d (now %0d)", sb[0].dcyc, cyc);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, want done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.dcyc));
          chk("result", 64'(result), 64'(e.r));
          chk("result_hi", 64'(result_hi), 64'(e.hi));
          chk("zero", 64'(zero), 64'(e.z));
          chk("ovf", 64'(ovf), 64'(e.o));
          chk("illegal", 64'(illegal), 64'(e.ill));
        end
      end
    end
  end

  initial begin
    #2;
    chk_reset_vals("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed corner cases, back to back.
    issue(4'b0100, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0000);
    issue(4'b1100, 32'd5, 32'd5, 16'h0000);
    issue(4'b0101, 32'd10, 32'h1234_5678, 16'hFFFF);
    issue(4'b0001, 32'd1, 32'h0000_0023, 16'h0000);
    issue(4'b0110, 32'h8000_0000, 32'd31, 16'h0000);
    issue(4'b1100, 32'h8000_0000, 32'd1, 16'h0000);

    // Long multiply with ignored requests while busy, then a request on the done cycle.
    issue(4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0000);
    repeat (5) issue(4'b0100, $urandom, $urandom, 16'h0000);
    for (int i = 0; i < 40 && busy_at(cyc); i++) idle(1);
    issue(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 16'h0000);
    issue(4'b0111, 32'd0, 32'h1234_5678, 16'h0000);
    for (int i = 0; i < 40 && busy_at(cyc); i++) idle(1);

    // Reset in the middle of a multiply.
    issue(4'b0111, 32'h0001_2345, 32'h0006_789A, 16'h0000);
    idle(9);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mul_rst");
    sb.delete();
    mult_acc = -1000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(40);
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 16'h0000);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) < 7)
        issue(4'($urandom_range(15)), opnd(), opnd(), 16'($urandom));
      else
        idle(1);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) idle(1);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending results, want 0", sb.size());
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
